wb_target_mem: RTL and testbench

- Wishbone classic-cycle target memory, the downstream consumer of wb_initiator_bfm transfers in the smoke benches.
- Replaces the ad-hoc single-register ack/data responder with a word-addressed RAM.
- Adds byte-lane writes, programmable wait states, address-range error response and cycle abort.

---
 rtl/wb_target_mem.sv | 189 ++++++++++++++++++
 tb/tb_wb_target_mem.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wb_target_mem.sv
// Wishbone classic-cycle target backed by a word-addressed RAM with byte-lane
// writes, programmable wait states, out-of-range error response and cycle abort.
module wb_target_mem #(
    parameter int unsigned                  ADDR_WIDTH  = 32,
    parameter int unsigned                  DATA_WIDTH  = 32,
    parameter int unsigned                  MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR   = '0,
    parameter int unsigned                  WAIT_STATES = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   adr,
    input  logic [DATA_WIDTH-1:0]   dat_w,
    output logic [DATA_WIDTH-1:0]   dat_r,
    input  logic                    cyc,
    output logic                    err,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic                    stb,
    output logic                    ack,
    input  logic                    we
);

    localparam int          NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
    logic [NB-1:0]           sel_q, sel_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   dat_r_q, dat_r_d;

    logic [ADDR_WIDTH-1:0]   req_adr_s;
    logic                    req_we_s;
    logic [DATA_WIDTH-1:0]   req_dat_s;
    logic [NB-1:0]           req_sel_s;
    logic [ADDR_WIDTH-1:0]   off_s;
    logic                    in_range_s;
    logic [IDX_W-1:0]        idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic                    go_resp_s;
    logic                    mem_we_s;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // With zero wait states the response is decided straight from the live bus,
    // otherwise from the request latched in IDLE.
    always_comb begin
        req_adr_s = adr_q;
        req_we_s  = we_q;
        req_dat_s = dat_w_q;
        req_sel_s = sel_q;
        if (state_q == ST_IDLE) begin
            req_adr_s = adr;
            req_we_s  = we;
            req_dat_s = dat_w;
            req_sel_s = sel;
        end else begin
            req_adr_s = adr_q;
        end
    end

    // Address decode; an underflowing subtraction lands out of range via the >= test.
    always_comb begin
        off_s      = req_adr_s - BASE_ADDR;
        in_range_s = (req_adr_s >= BASE_ADDR) &&
                     ((off_s >> OFF_W) < ADDR_WIDTH'(MEM_DEPTH));
        idx_s      = off_s[OFF_W +: IDX_W];
        rd_word_s  = mem[idx_s];
    end

    // Next-state, request latching and registered response computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        dat_w_d   = dat_w_q;
        sel_d     = sel_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_r_d   = '0;
        go_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cyc && stb) begin
                    adr_d   = adr;
                    we_d    = we;
                    dat_w_d = dat_w;
                    sel_d   = sel;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        go_resp_s = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!cyc) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d     = cnt_q - 4'd1;
                    go_resp_s = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (go_resp_s) begin
            if (in_range_s) begin
                ack_d = 1'b1;
                if (!req_we_s) begin
                    dat_r_d = rd_word_s;
                end else begin
                    dat_r_d = '0;
                end
            end else begin
                err_d = 1'b1;
            end
        end else begin
            ack_d = 1'b0;
        end
        mem_we_s = go_resp_s && in_range_s && req_we_s && !reset;
    end

    // Control and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_w_q <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            dat_w_q <= dat_w_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_r_q <= dat_r_d;
        end
    end

    // Byte-lane write commits on the edge that enters RESP; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int i = 0; i < NB; i++) begin
                if (req_sel_s[i]) begin
                    mem[idx_s][i*8 +: 8] <= req_dat_s[i*8 +: 8];
                end
            end
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign dat_r = dat_r_q;

endmodule

// File: tb/tb_wb_target_mem.sv
// Directed bench for wb_target_mem: five instances cover zero/3/5/2 wait states
// and an offset, shallow memory for the range-error cases.
module tb_wb_target_mem;

    logic        clock;
    logic        reset;
    logic [31:0] adr_s;
    logic [31:0] dat_w_s;
    logic [3:0]  sel_s;
    logic        we_s;
    logic        cyc_s   [5];
    logic        stb_s   [5];
    logic        ack_s   [5];
    logic        err_s   [5];
    logic [31:0] dat_r_s [5];

    int tests;
    int fails;

    wb_target_mem #(.WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset(reset), .adr(adr_s), .dat_w(dat_w_s), .dat_r(dat_r_s[0]),
        .cyc(cyc_s[0]), .err(err_s[0]), .sel(sel_s), .stb(stb_s[0]), .ack(ack_s[0]), .we(we_s));

    wb_target_mem #(.WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset(reset), .adr(adr_s), .dat_w(dat_w_s), .dat_r(dat_r_s[1]),
        .cyc(cyc_s[1]), .err(err_s[1]), .sel(sel_s), .stb(stb_s[1]), .ack(ack_s[1]), .we(we_s));

    wb_target_mem #(.WAIT_STATES(5)) u_ws5 (
        .clock(clock), .reset(reset), .adr(adr_s), .dat_w(dat_w_s), .dat_r(dat_r_s[2]),
        .cyc(cyc_s[2]), .err(err_s[2]), .sel(sel_s), .stb(stb_s[2]), .ack(ack_s[2]), .we(we_s));

    wb_target_mem #(.WAIT_STATES(2)) u_ws2 (
        .clock(clock), .reset(reset), .adr(adr_s), .dat_w(dat_w_s), .dat_r(dat_r_s[3]),
        .cyc(cyc_s[3]), .err(err_s[3]), .sel(sel_s), .stb(stb_s[3]), .ack(ack_s[3]), .we(we_s));

    wb_target_mem #(.WAIT_STATES(0), .MEM_DEPTH(256), .BASE_ADDR(32'h0000_1000)) u_rng (
        .clock(clock), .reset(reset), .adr(adr_s), .dat_w(dat_w_s), .dat_r(dat_r_s[4]),
        .cyc(cyc_s[4]), .err(err_s[4]), .sel(sel_s), .stb(stb_s[4]), .ack(ack_s[4]), .we(we_s));

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transfer: latency, termination type, data, quiet data before and after.
    task automatic xfer(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_dat, input string tag);
        int          lat;
        logic [31:0] pre_nz;
        logic        got_ack;
        logic        got_err;
        logic [31:0] got_dat;
        lat = -1; pre_nz = 32'h0; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0;
        @(posedge clock); #1;
        adr_s = a; dat_w_s = d; sel_s = s; we_s = w;
        cyc_s[u] = 1'b1; stb_s[u] = 1'b1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(posedge clock); #1;
            if (ack_s[u] || err_s[u]) begin
                lat = k; got_ack = ack_s[u]; got_err = err_s[u]; got_dat = dat_r_s[u];
                cyc_s[u] = 1'b0; stb_s[u] = 1'b0;
            end else begin
                pre_nz = pre_nz | dat_r_s[u];
            end
        end
        cyc_s[u] = 1'b0; stb_s[u] = 1'b0;
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " ack"}, 32'(got_ack), 32'(!exp_err));
        check_eq({tag, " err"}, 32'(got_err), 32'(exp_err));
        check_eq({tag, " dat_r"}, got_dat, exp_dat);
        check_eq({tag, " dat_r before resp"}, pre_nz, 32'h0);
        @(posedge clock); #1;
        check_eq({tag, " resp width"}, 32'(ack_s[u] | err_s[u]), 32'h0);
        check_eq({tag, " dat_r after resp"}, dat_r_s[u], 32'h0);
    endtask

    // Write that is killed by dropping cyc (or by reset) while waiting.
    task automatic abort_xfer(input int u, input logic [31:0] a, input logic [31:0] d,
                              input int keep, input logic use_rst, input string tag);
        int hits;
        hits = 0;
        @(posedge clock); #1;
        adr_s = a; dat_w_s = d; sel_s = 4'hF; we_s = 1'b1;
        cyc_s[u] = 1'b1; stb_s[u] = 1'b1;
        repeat (keep) begin
            @(posedge clock); #1;
            hits += int'(ack_s[u] | err_s[u]);
        end
        if (use_rst) begin
            reset = 1'b1;
            @(posedge clock); #1;
            check_eq({tag, " ack/err in reset"}, 32'(ack_s[u] | err_s[u]), 32'h0);
            check_eq({tag, " dat_r in reset"}, dat_r_s[u], 32'h0);
            reset = 1'b0;
        end
        cyc_s[u] = 1'b0; stb_s[u] = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            hits += int'(ack_s[u] | err_s[u]);
        end
        check_eq({tag, " no response"}, 32'(hits), 32'h0);
    endtask

    initial begin
        tests = 0; fails = 0;
        clock = 1'b0; reset = 1'b1;
        adr_s = 32'h0; dat_w_s = 32'h0; sel_s = 4'h0; we_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc_s[i] = 1'b0; stb_s[i] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("reset u%0d ack/err", i), 32'(ack_s[i] | err_s[i]), 32'h0);
            check_eq($sformatf("reset u%0d dat_r", i), dat_r_s[i], 32'h0);
        end
        reset = 1'b0;

        // zero wait states: full word, byte lanes, empty sel
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 32'h0,         "ws0 wr");
        xfer(0, 1'b0, 32'h10, 32'h0,         4'hF, 1, 1'b0, 32'hDEAD_BEEF, "ws0 rd");
        xfer(0, 1'b1, 32'h13, 32'h1122_3344, 4'hF, 1, 1'b0, 32'h0,         "ws0 wr unaligned");
        xfer(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'h5, 1, 1'b0, 32'h0,         "lane wr");
        xfer(0, 1'b0, 32'h10, 32'h0,         4'hF, 1, 1'b0, 32'h11BB_33DD, "lane rd");
        xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1, 1'b0, 32'h0,         "sel0 wr");
        xfer(0, 1'b0, 32'h10, 32'h0,         4'hF, 1, 1'b0, 32'h11BB_33DD, "sel0 rd");

        // three wait states
        xfer(1, 1'b1, 32'h40, 32'hA5A5_5A5A, 4'hF, 4, 1'b0, 32'h0,         "ws3 wr");
        xfer(1, 1'b0, 32'h40, 32'h0,         4'hF, 4, 1'b0, 32'hA5A5_5A5A, "ws3 rd");

        // range errors leave neighbouring words untouched
        xfer(4, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, 1, 1'b0, 32'h0,         "rng wr lo");
        xfer(4, 1'b1, 32'h13FC, 32'h0506_0708, 4'hF, 1, 1'b0, 32'h0,         "rng wr hi");
        xfer(4, 1'b1, 32'h1400, 32'hFFFF_FFFF, 4'hF, 1, 1'b1, 32'h0,         "rng wr over");
        xfer(4, 1'b1, 32'h0FFC, 32'hEEEE_EEEE, 4'hF, 1, 1'b1, 32'h0,         "rng wr under");
        xfer(4, 1'b0, 32'h1400, 32'h0,         4'hF, 1, 1'b1, 32'h0,         "rng rd over");
        xfer(4, 1'b0, 32'h1000, 32'h0,         4'hF, 1, 1'b0, 32'h0102_0304, "rng rd lo");
        xfer(4, 1'b0, 32'h13FC, 32'h0,         4'hF, 1, 1'b0, 32'h0506_0708, "rng rd hi");

        // abort by dropping cyc during wait states
        xfer(2, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 6, 1'b0, 32'h0, "ws5 wr");
        abort_xfer(2, 32'h20, 32'hFFFF_0000, 2, 1'b0, "abort");
        xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 6, 1'b0, 32'h1234_5678, "abort rd");

        // reset during wait states discards the write and keeps memory
        xfer(3, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 3, 1'b0, 32'h0, "ws2 wr");
        abort_xfer(3, 32'h30, 32'h0BAD_BEEF, 1, 1'b1, "rst mid");
        xfer(3, 1'b0, 32'h30, 32'h0, 4'hF, 3, 1'b0, 32'hCAFE_F00D, "rst rd");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1, 1'b0, 32'h11BB_33DD, "rst keep mem");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
